// File: rtl/run_monitor.sv
// Run monitor: resets a CPU under test, runs it until its PC stalls or a cycle
// limit expires, and collects a signature of the ALU results plus flag statistics.
module run_monitor #(
  parameter int          DW          = 32,
  parameter int          CW          = 16,
  parameter int          RST_CYCLES  = 4,
  parameter int          MAX_CYCLES  = 1024,
  parameter int          HALT_REPEAT = 3,
  parameter logic [DW-1:0] EXP_SIG   = '0
) (
  input  logic          clk_low,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] pc,
  input  logic [DW-1:0] f,
  input  logic          zf,
  input  logic          of,
  output logic          cpu_rst,
  output logic          busy,
  output logic          done,
  output logic          halted,
  output logic          timeout,
  output logic          pass,
  output logic [CW-1:0] cycles,
  output logic [7:0]    of_count,
  output logic [7:0]    zf_count,
  output logic [DW-1:0] signature
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] MAX_C   = CW'(MAX_CYCLES);
  localparam logic [7:0]    RST_C   = 8'(RST_CYCLES);
  localparam logic [3:0]    HALT_C  = 4'(HALT_REPEAT);

  state_t        state_q, state_d;
  logic [7:0]    rst_cnt_q, rst_cnt_d;
  logic [CW-1:0] cycles_q, cycles_d;
  logic [7:0]    of_count_q, of_count_d;
  logic [7:0]    zf_count_q, zf_count_d;
  logic [DW-1:0] sig_q, sig_d;
  logic [DW-1:0] prev_pc_q, prev_pc_d;
  logic          prev_valid_q, prev_valid_d;
  logic [3:0]    rep_q, rep_d;
  logic          halted_q, halted_d;
  logic          timeout_q, timeout_d;
  logic          pass_q, pass_d;

  logic          launch;
  logic          in_run;
  logic [3:0]    rep_next;
  logic [CW-1:0] cycles_inc;
  logic [DW-1:0] sig_next;
  logic          halt_hit;
  logic          limit_hit;

  // Shared event decode used by both the FSM and the datapath.
  always_comb begin
    launch     = start && (state_q == S_IDLE || state_q == S_DONE);
    in_run     = (state_q == S_RUN);
    rep_next   = (prev_valid_q && pc == prev_pc_q) ? rep_q + 4'd1 : 4'd0;
    cycles_inc = cycles_q + {{(CW-1){1'b0}}, 1'b1};
    sig_next   = {sig_q[DW-2:0], sig_q[DW-1]} ^ f;
    halt_hit   = in_run && (rep_next == HALT_C);
    limit_hit  = in_run && (cycles_inc == MAX_C);
  end

  // State register
  always_ff @(posedge clk_low) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RESET;
      S_RESET: if (rst_cnt_q <= 8'd1) state_d = S_RUN;
      S_RUN:   if (halt_hit || limit_hit) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RESET;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from state only
  always_comb begin
    cpu_rst = (state_q != S_RUN);
    busy    = (state_q == S_RESET) || (state_q == S_RUN);
    done    = (state_q == S_DONE);
  end

  // Datapath next-state; the terminating RUN cycle still updates the statistics.
  always_comb begin
    rst_cnt_d    = rst_cnt_q;
    cycles_d     = cycles_q;
    of_count_d   = of_count_q;
    zf_count_d   = zf_count_q;
    sig_d        = sig_q;
    prev_pc_d    = prev_pc_q;
    prev_valid_d = prev_valid_q;
    rep_d        = rep_q;
    halted_d     = halted_q;
    timeout_d    = timeout_q;
    pass_d       = pass_q;
    if (launch) begin
      rst_cnt_d    = RST_C;
      cycles_d     = '0;
      of_count_d   = 8'd0;
      zf_count_d   = 8'd0;
      sig_d        = '0;
      prev_pc_d    = '0;
      prev_valid_d = 1'b0;
      rep_d        = 4'd0;
      halted_d     = 1'b0;
      timeout_d    = 1'b0;
      pass_d       = 1'b0;
    end else if (state_q == S_RESET) begin
      if (rst_cnt_q != 8'd0) rst_cnt_d = rst_cnt_q - 8'd1;
    end else if (in_run) begin
      cycles_d     = cycles_inc;
      sig_d        = sig_next;
      if (of && of_count_q != 8'hFF) of_count_d = of_count_q + 8'd1;
      if (zf && zf_count_q != 8'hFF) zf_count_d = zf_count_q + 8'd1;
      prev_pc_d    = pc;
      prev_valid_d = 1'b1;
      rep_d        = rep_next;
      if (halt_hit) begin
        halted_d = 1'b1;
        pass_d   = (sig_next == EXP_SIG);
      end else if (limit_hit) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_low) begin
    if (rst) begin
      rst_cnt_q    <= 8'd0;
      cycles_q     <= '0;
      of_count_q   <= 8'd0;
      zf_count_q   <= 8'd0;
      sig_q        <= '0;
      prev_pc_q    <= '0;
      prev_valid_q <= 1'b0;
      rep_q        <= 4'd0;
      halted_q     <= 1'b0;
      timeout_q    <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      rst_cnt_q    <= rst_cnt_d;
      cycles_q     <= cycles_d;
      of_count_q   <= of_count_d;
      zf_count_q   <= zf_count_d;
      sig_q        <= sig_d;
      prev_pc_q    <= prev_pc_d;
      prev_valid_q <= prev_valid_d;
      rep_q        <= rep_d;
      halted_q     <= halted_d;
      timeout_q    <= timeout_d;
      pass_q       <= pass_d;
    end
  end

  assign halted    = halted_q;
  assign timeout   = timeout_q;
  assign pass      = pass_q;
  assign cycles    = cycles_q;
  assign of_count  = of_count_q;
  assign zf_count  = zf_count_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: a cycle table for reset/start timing, then
// hand-written halt, timeout, signature, saturation and reset sequences.
module tb_run_monitor;

  logic        clk_low = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] pc = 32'd0;
  logic [31:0] f = 32'd0;
  logic        zf = 1'b0;
  logic        of = 1'b0;

  logic        cpu_rst_a, busy_a, done_a, halted_a, timeout_a, pass_a;
  logic [15:0] cycles_a;
  logic [7:0]  of_count_a, zf_count_a;
  logic [31:0] signature_a;

  logic        cpu_rst_b, busy_b, done_b, halted_b, timeout_b, pass_b;
  logic [15:0] cycles_b;
  logic [7:0]  of_count_b, zf_count_b;
  logic [31:0] signature_b;

  int checks = 0;
  int errors = 0;

  // A: short limit, expects signature 0x18. B: long limit, expects 0x19.
  run_monitor #(.DW(32), .CW(16), .RST_CYCLES(4), .MAX_CYCLES(16), .HALT_REPEAT(3),
                .EXP_SIG(32'h18)) dut_a (
    .clk_low(clk_low), .rst(rst), .start(start), .pc(pc), .f(f), .zf(zf), .of(of),
    .cpu_rst(cpu_rst_a), .busy(busy_a), .done(done_a), .halted(halted_a),
    .timeout(timeout_a), .pass(pass_a), .cycles(cycles_a), .of_count(of_count_a),
    .zf_count(zf_count_a), .signature(signature_a));

  run_monitor #(.DW(32), .CW(16), .RST_CYCLES(4), .MAX_CYCLES(1024), .HALT_REPEAT(3),
                .EXP_SIG(32'h19)) dut_b (
    .clk_low(clk_low), .rst(rst), .start(start), .pc(pc), .f(f), .zf(zf), .of(of),
    .cpu_rst(cpu_rst_b), .busy(busy_b), .done(done_b), .halted(halted_b),
    .timeout(timeout_b), .pass(pass_b), .cycles(cycles_b), .of_count(of_count_b),
    .zf_count(zf_count_b), .signature(signature_b));

  always #5 clk_low = ~clk_low;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        rst;
    logic        start;
    logic [31:0] pc;
    logic [15:0] exp_cycles;
    logic        exp_cpu_rst;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_low);
    #1;
  endtask

  task automatic do_rst();
    rst = 1'b1; start = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
  endtask

  task automatic run_cyc(input logic [31:0] p, input logic [31:0] fv, input logic z, input logic o);
    pc = p; f = fv; zf = z; of = o;
    step();
  endtask

  initial begin
    // rst, start, pc, cycles, cpu_rst, busy, done
    vecs[0]  = '{1'b1, 1'b0, 32'd0,  16'd0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'd0,  16'd0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'd0,  16'd0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'd0,  16'd0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 32'd0,  16'd0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'd0,  16'd0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 32'd0,  16'd0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 32'd0,  16'd0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 32'd4,  16'd1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 32'd8,  16'd2, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'd12, 16'd3, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 32'd16, 16'd4, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 12; i++) begin
      rst = vecs[i].rst; start = vecs[i].start; pc = vecs[i].pc;
      step();
      chk($sformatf("vec%0d_cpu_rst", i), 32'(cpu_rst_a), 32'(vecs[i].exp_cpu_rst));
      chk($sformatf("vec%0d_busy", i),    32'(busy_a),    32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_done", i),    32'(done_a),    32'(vecs[i].exp_done));
      chk($sformatf("vec%0d_cycles", i),  32'(cycles_a),  32'(vecs[i].exp_cycles));
      $display("vec %0d rst=%0d start=%0d pc=%0h cpu_rst=%0d busy=%0d cycles=%0d",
               i, rst, start, pc, cpu_rst_a, busy_a, cycles_a);
    end
    start = 1'b0;

    // Halt: pc climbs to 0x28 over 10 cycles, then stalls for 3 cycles.
    do_rst();
    do_start();
    for (int k = 1; k <= 13; k++) begin
      run_cyc(32'(4 * (k > 10 ? 10 : k)), 32'd0, 1'b0, 1'b0);
      if (k == 12) chk("halt_not_early", 32'(done_a), 32'd0);
    end
    chk("halt_done",    32'(done_a),    32'd1);
    chk("halt_halted",  32'(halted_a),  32'd1);
    chk("halt_timeout", 32'(timeout_a), 32'd0);
    chk("halt_cycles",  32'(cycles_a),  32'd13);
    chk("halt_pass",    32'(pass_a),    32'd0);
    chk("halt_b_done",  32'(done_b),    32'd1);
    run_cyc(32'h100, 32'h55, 1'b1, 1'b1);
    chk("done_hold_cycles",  32'(cycles_a),   32'd13);
    chk("done_hold_cpu_rst", 32'(cpu_rst_a),  32'd1);
    chk("done_hold_of",      32'(of_count_a), 32'd0);
    $display("halt test done=%0d halted=%0d cycles=%0d", done_a, halted_a, cycles_a);

    // Restart straight from DONE, then signature/pass run.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_busy",    32'(busy_a),    32'd1);
    chk("restart_done",    32'(done_a),    32'd0);
    chk("restart_cpu_rst", 32'(cpu_rst_a), 32'd1);
    chk("restart_cycles",  32'(cycles_a),  32'd0);
    chk("restart_halted",  32'(halted_a),  32'd0);
    repeat (4) step();
    chk("restart_run", 32'(cpu_rst_a), 32'd0);
    run_cyc(32'h10, 32'd1, 1'b0, 1'b0);
    run_cyc(32'h14, 32'd2, 1'b0, 1'b0);
    run_cyc(32'h18, 32'd3, 1'b0, 1'b0);
    repeat (3) run_cyc(32'h18, 32'd0, 1'b0, 1'b0);
    chk("sig_a_value",  signature_a,       32'h18);
    chk("sig_a_halted", 32'(halted_a),     32'd1);
    chk("sig_a_cycles", 32'(cycles_a),     32'd6);
    chk("sig_a_pass",   32'(pass_a),       32'd1);
    chk("sig_b_value",  signature_b,       32'h18);
    chk("sig_b_pass",   32'(pass_b),       32'd0);
    $display("signature test sig=%0h pass_a=%0d pass_b=%0d", signature_a, pass_a, pass_b);

    // Timeout at MAX_CYCLES=16 on A.
    do_rst();
    do_start();
    for (int k = 1; k <= 16; k++) begin
      run_cyc(32'(4 * k), 32'd0, 1'b0, 1'b0);
      if (k == 15) chk("tmo_not_early", 32'(done_a), 32'd0);
    end
    chk("tmo_done",    32'(done_a),    32'd1);
    chk("tmo_timeout", 32'(timeout_a), 32'd1);
    chk("tmo_halted",  32'(halted_a),  32'd0);
    chk("tmo_cycles",  32'(cycles_a),  32'd16);
    chk("tmo_pass",    32'(pass_a),    32'd0);
    chk("tmo_b_busy",  32'(busy_b),    32'd1);
    $display("timeout test timeout=%0d cycles=%0d", timeout_a, cycles_a);

    // Halt and limit on the same cycle: halt wins.
    do_rst();
    do_start();
    for (int k = 1; k <= 16; k++) run_cyc(32'(4 * (k > 13 ? 13 : k)), 32'd0, 1'b0, 1'b0);
    chk("prio_halted",  32'(halted_a),  32'd1);
    chk("prio_timeout", 32'(timeout_a), 32'd0);
    chk("prio_cycles",  32'(cycles_a),  32'd16);
    $display("priority test halted=%0d timeout=%0d", halted_a, timeout_a);

    // First RUN cycle never counts as a repeat, even with pc equal to the cleared value.
    do_rst();
    do_start();
    repeat (3) run_cyc(32'd0, 32'd0, 1'b0, 1'b0);
    chk("first_not_rep", 32'(done_a), 32'd0);
    run_cyc(32'd0, 32'd0, 1'b0, 1'b0);
    chk("first_halt",   32'(halted_a), 32'd1);
    chk("first_cycles", 32'(cycles_a), 32'd4);
    $display("first-cycle test cycles=%0d halted=%0d", cycles_a, halted_a);

    // Saturation over 300 RUN cycles on B.
    do_rst();
    do_start();
    for (int k = 1; k <= 300; k++) run_cyc(32'(4 * k), 32'd0, 1'b1, 1'b1);
    chk("sat_b_of",     32'(of_count_b), 32'd255);
    chk("sat_b_zf",     32'(zf_count_b), 32'd255);
    chk("sat_b_cycles", 32'(cycles_b),   32'd300);
    chk("sat_a_of",     32'(of_count_a), 32'd16);
    chk("sat_a_zf",     32'(zf_count_a), 32'd16);
    $display("saturation test of=%0d zf=%0d", of_count_b, zf_count_b);

    // Mid-run reset at RUN cycle 5, with start asserted alongside rst.
    do_rst();
    do_start();
    for (int k = 1; k <= 5; k++) run_cyc(32'(4 * k), 32'd5, 1'b0, 1'b1);
    chk("mid_cycles", 32'(cycles_a),   32'd5);
    chk("mid_of",     32'(of_count_a), 32'd5);
    chk("mid_sig",    signature_a,     32'h63);
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    chk("mrst_cpu_rst", 32'(cpu_rst_a),   32'd1);
    chk("mrst_busy",    32'(busy_a),      32'd0);
    chk("mrst_done",    32'(done_a),      32'd0);
    chk("mrst_cycles",  32'(cycles_a),    32'd0);
    chk("mrst_of",      32'(of_count_a),  32'd0);
    chk("mrst_sig",     signature_a,      32'd0);
    chk("mrst_halted",  32'(halted_a),    32'd0);
    chk("mrst_timeout", 32'(timeout_a),   32'd0);
    step();
    chk("idle_stays", 32'(busy_a), 32'd0);
    $display("mid-run reset test busy=%0d cpu_rst=%0d", busy_a, cpu_rst_a);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_monitor.md
RUN_MONITOR -- requirements
Module: run_monitor

Interface
REQ-001 Parameter DW, default 32, width of monitored PC and ALU result buses.
REQ-002 Parameter CW, default 16, width of the cycle counter.
REQ-003 Parameter RST_CYCLES, default 4, number of cycles cpu_rst is held before a run (range 1..255).
REQ-004 Parameter MAX_CYCLES, default 1024, run-cycle limit before timeout (range 1..2^CW-1).
REQ-005 Parameter HALT_REPEAT, default 3, consecutive unchanged-PC cycles that signal halt (range 1..15).
REQ-006 Parameter EXP_SIG, default 0, expected final signature (DW bits).
REQ-007 clk_low  in  1  sole clock; all state updates on its rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 start  in  1  single-cycle request to begin a run.
REQ-010 pc  in  DW  CPU program counter.
REQ-011 f  in  DW  CPU ALU result.
REQ-012 zf  in  1  CPU zero flag.
REQ-013 of  in  1  CPU overflow flag.
REQ-014 cpu_rst  out  1  reset driven to the CPU under monitor.
REQ-015 busy  out  1  high in the RESET and RUN states.
REQ-016 done  out  1  high in the DONE state.
REQ-017 halted  out  1  run ended by halt detection.
REQ-018 timeout  out  1  run ended by the cycle limit.
REQ-019 pass  out  1  halted and signature == EXP_SIG.
REQ-020 cycles  out  CW  number of RUN cycles elapsed.
REQ-021 of_count  out  8  number of RUN cycles with of=1, saturating at 255.
REQ-022 zf_count  out  8  number of RUN cycles with zf=1, saturating at 255.
REQ-023 signature  out  DW  running signature of f.

Function
REQ-024 The FSM SHALL have four states: IDLE, RESET, RUN and DONE, encoded as 2 bits.
REQ-025 In IDLE, cpu_rst SHALL be 1; start SHALL clear all statistics, load the reset counter with RST_CYCLES, and move the FSM to RESET on the next edge.
REQ-026 In RESET, cpu_rst SHALL be 1 for exactly RST_CYCLES cycles, then the FSM SHALL enter RUN.
REQ-027 In RUN, cpu_rst SHALL be 0.
REQ-028 On every RUN cycle, cycles SHALL increment by 1.
REQ-029 On every RUN cycle, signature SHALL update to {signature[DW-2:0], signature[DW-1]} XOR f.
REQ-030 On every RUN cycle, of_count SHALL increment when of=1 and zf_count SHALL increment when zf=1; both SHALL saturate at 255 without wrap.
REQ-031 Halt detection SHALL register the previous pc; a repeat counter SHALL increment when pc equals the previous pc and clear to 0 otherwise.
REQ-032 The first RUN cycle SHALL NOT count as a repeat, since no valid previous pc exists yet.
REQ-033 When the repeat counter reaches HALT_REPEAT, halted SHALL be set to 1 and the FSM SHALL enter DONE.
REQ-034 When cycles reaches MAX_CYCLES without halt, timeout SHALL be set to 1 and the FSM SHALL enter DONE.
REQ-035 When halt and the cycle limit occur on the same cycle, halt SHALL take priority: halted=1 and timeout=0.
REQ-036 The statistics update on the terminating cycle SHALL still be applied.
REQ-037 In DONE, cpu_rst SHALL be 1 to freeze the CPU, and all statistics and flags SHALL hold.
REQ-038 pass SHALL be a registered output set on entry to DONE as halted AND (final signature == EXP_SIG).
REQ-039 In DONE, start SHALL restart the sequence exactly as from IDLE, including clearing the statistics.
REQ-040 start SHALL be ignored in the RESET and RUN states.
REQ-041 The outputs busy and done SHALL be decoded from the state only.

Reset
REQ-042 rst=1 SHALL force the FSM to IDLE on the next edge, from any state including mid-run.
REQ-043 rst=1 SHALL set cpu_rst=1 and clear busy, done, halted, timeout, pass, cycles, of_count, zf_count, signature, the repeat counter and the previous pc to 0.
REQ-044 rst SHALL take priority over start on the same cycle.

Verification
REQ-045 Reset and start: rst for 3 cycles, then start pulse with RST_CYCLES=4 -> cpu_rst=1 for exactly 4 cycles after the start edge, busy=1, then RUN with cpu_rst=0.
REQ-046 Halt: pc increments for 10 cycles then holds at 0x28, f=0, HALT_REPEAT=3 -> done after 3 repeat cycles, halted=1, timeout=0, cycles=13.
REQ-047 Timeout: MAX_CYCLES=16 with pc incrementing every cycle -> done with timeout=1, halted=0, cycles=16, pass=0.
REQ-048 Signature and pass: f=1,2,3 followed by a halt with f=0 and EXP_SIG set to the computed value -> pass=1; EXP_SIG off by one bit -> pass=0.
REQ-049 Saturation: of=1 and zf=1 held for 300 RUN cycles -> of_count=255 and zf_count=255.
REQ-050 Mid-run reset, plus restart from DONE: rst asserted at cycle 5 of RUN -> IDLE with all outputs cleared and cpu_rst=1; start in DONE -> statistics cleared and a new RESET phase begins.
